card_hand_reader: RTL and testbench

Consumer end of the card-generation interface. Detects the rising edge of `work_done_card_generation` and captures the nine 6-bit card numbers. It then validates them one per cycle (range and uniqueness) and decodes each into rank and suit. The decoded cards are streamed one at a time over a valid/ready handshake to the downstream game-logic / display blocks.

---
 rtl/card_pkg.sv | 21 ++
 rtl/card_decode.sv | 40 ++++
 rtl/card_hand_reader.sv | 142 ++++++++++++++
 tb/tb_card_hand_reader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/card_pkg.sv
// Shared constants, widths and reader state encoding for the card hand reader.
package card_pkg;

   localparam int unsigned NUM_CARDS = 9;
   localparam int unsigned DECK_SIZE = 52;
   localparam int unsigned RANKS     = 13;

   localparam int unsigned CARD_W = 6;
   localparam int unsigned RANK_W = 4;
   localparam int unsigned SUIT_W = 2;
   localparam int unsigned IDX_W  = 4;

   typedef enum logic [2:0] {
      StIdle,
      StCheck,
      StSend,
      StDone,
      StErr
   } reader_state_t;

endpackage

// File: rtl/card_decode.sv
// Combinational card code decoder: code -> rank (1..Ranks), suit (0..3), in-range flag.
module card_decode
   import card_pkg::*;
#(
   parameter int unsigned DeckSize = 52,
   parameter int unsigned Ranks    = 13
) (
   input  logic [CARD_W-1:0] code_i,
   output logic [RANK_W-1:0] rank_o,
   output logic [SUIT_W-1:0] suit_o,
   output logic              in_range_o
);

   localparam logic [CARD_W-1:0] Th1  = CARD_W'(Ranks);
   localparam logic [CARD_W-1:0] Th2  = CARD_W'(2 * Ranks);
   localparam logic [CARD_W-1:0] Th3  = CARD_W'(3 * Ranks);
   localparam logic [CARD_W-1:0] Deck = CARD_W'(DeckSize);

   logic [CARD_W-1:0] rem;

   // Compare-subtract against the suit boundaries instead of a divider.
   always_comb begin
      suit_o = '0;
      rem    = code_i;
      if (code_i >= Th3) begin
         suit_o = SUIT_W'(3);
         rem    = code_i - Th3;
      end else if (code_i >= Th2) begin
         suit_o = SUIT_W'(2);
         rem    = code_i - Th2;
      end else if (code_i >= Th1) begin
         suit_o = SUIT_W'(1);
         rem    = code_i - Th1;
      end
      rank_o = RANK_W'(rem) + RANK_W'(1);
   end

   assign in_range_o = (code_i < Deck);

endmodule

// File: rtl/card_hand_reader.sv
// Latches a nine-card hand on the generator's done edge, validates it, then streams
// decoded cards over valid/ready.
module card_hand_reader #(
   parameter int unsigned DECK_SIZE = 52,
   parameter int unsigned RANKS     = 13
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [card_pkg::CARD_W-1:0]  card1_num,
   input  logic [card_pkg::CARD_W-1:0]  card2_num,
   input  logic [card_pkg::CARD_W-1:0]  card3_num,
   input  logic [card_pkg::CARD_W-1:0]  card4_num,
   input  logic [card_pkg::CARD_W-1:0]  card5_num,
   input  logic [card_pkg::CARD_W-1:0]  card6_num,
   input  logic [card_pkg::CARD_W-1:0]  card7_num,
   input  logic [card_pkg::CARD_W-1:0]  card8_num,
   input  logic [card_pkg::CARD_W-1:0]  card9_num,
   input  logic                         work_done_card_generation,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [card_pkg::IDX_W-1:0]   out_index,
   output logic [card_pkg::RANK_W-1:0]  out_rank,
   output logic [card_pkg::SUIT_W-1:0]  out_suit,
   output logic                         hand_done,
   output logic                         hand_error,
   output logic [card_pkg::IDX_W-1:0]   err_index
);
   import card_pkg::*;

   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_CARDS - 1);

   reader_state_t       state_q;
   logic                wd_q;
   logic [CARD_W-1:0]   card_q [NUM_CARDS];
   logic [CARD_W-1:0]   card_in [NUM_CARDS];
   logic [DECK_SIZE-1:0] seen_q;
   logic [IDX_W-1:0]    idx_q;
   logic                out_valid_q, hand_done_q, hand_error_q;
   logic [IDX_W-1:0]    err_index_q;

   logic                start;
   logic [CARD_W-1:0]   dec_code;
   logic [RANK_W-1:0]   dec_rank;
   logic [SUIT_W-1:0]   dec_suit;
   logic                dec_in_range;
   logic                bad_card;
   logic                presenting;

   always_comb begin
      card_in[0] = card1_num;
      card_in[1] = card2_num;
      card_in[2] = card3_num;
      card_in[3] = card4_num;
      card_in[4] = card5_num;
      card_in[5] = card6_num;
      card_in[6] = card7_num;
      card_in[7] = card8_num;
      card_in[8] = card9_num;
   end

   assign start    = work_done_card_generation & ~wd_q;
   assign dec_code = card_q[idx_q];
   assign bad_card = !dec_in_range || seen_q[dec_code];

   card_decode #(
      .DeckSize (DECK_SIZE),
      .Ranks    (RANKS)
   ) u_card_decode (
      .code_i     (dec_code),
      .rank_o     (dec_rank),
      .suit_o     (dec_suit),
      .in_range_o (dec_in_range)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         wd_q         <= 1'b0;
         seen_q       <= '0;
         idx_q        <= '0;
         out_valid_q  <= 1'b0;
         hand_done_q  <= 1'b0;
         hand_error_q <= 1'b0;
         err_index_q  <= '0;
         for (int i = 0; i < NUM_CARDS; i++) card_q[i] <= '0;
      end else begin
         wd_q <= work_done_card_generation;
         case (state_q)
            StIdle, StDone, StErr: begin
               if (start) begin
                  for (int i = 0; i < NUM_CARDS; i++) card_q[i] <= card_in[i];
                  seen_q       <= '0;
                  idx_q        <= '0;
                  hand_done_q  <= 1'b0;
                  hand_error_q <= 1'b0;
                  err_index_q  <= '0;
                  state_q      <= StCheck;
               end
            end
            StCheck: begin
               if (bad_card) begin
                  err_index_q  <= idx_q;
                  hand_error_q <= 1'b1;
                  state_q      <= StErr;
               end else begin
                  seen_q[dec_code] <= 1'b1;
                  if (idx_q == LastIdx) begin
                     idx_q       <= '0;
                     out_valid_q <= 1'b1;
                     state_q     <= StSend;
                  end else begin
                     idx_q <= idx_q + IDX_W'(1);
                  end
               end
            end
            StSend: begin
               // idx stays on the last card after acceptance so DONE keeps showing it.
               if (out_ready) begin
                  if (idx_q == LastIdx) begin
                     out_valid_q <= 1'b0;
                     hand_done_q <= 1'b1;
                     state_q     <= StDone;
                  end else begin
                     idx_q <= idx_q + IDX_W'(1);
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign presenting = (state_q == StSend) || (state_q == StDone);
   assign out_valid  = out_valid_q;
   assign out_index  = presenting ? idx_q    : '0;
   assign out_rank   = presenting ? dec_rank : '0;
   assign out_suit   = presenting ? dec_suit : '0;
   assign hand_done  = hand_done_q;
   assign hand_error = hand_error_q;
   assign err_index  = err_index_q;

endmodule

// File: tb/tb_card_hand_reader.sv
// Self-checking bench for card_hand_reader: directed scenarios plus randomized hands
// against a transaction-level reference model.
module tb_card_hand_reader;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] c [9];
   logic       wd;
   logic       ready;
   logic       out_valid, hand_done, hand_error;
   logic [3:0] out_index, out_rank, err_index;
   logic [1:0] out_suit;

   always #5 clk = ~clk;

   card_hand_reader dut (
      .clk                       (clk),
      .rst                       (rst),
      .card1_num                 (c[0]),
      .card2_num                 (c[1]),
      .card3_num                 (c[2]),
      .card4_num                 (c[3]),
      .card5_num                 (c[4]),
      .card6_num                 (c[5]),
      .card7_num                 (c[6]),
      .card8_num                 (c[7]),
      .card9_num                 (c[8]),
      .work_done_card_generation (wd),
      .out_valid                 (out_valid),
      .out_ready                 (ready),
      .out_index                 (out_index),
      .out_rank                  (out_rank),
      .out_suit                  (out_suit),
      .hand_done                 (hand_done),
      .hand_error                (hand_error),
      .err_index                 (err_index)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: the whole hand outcome is decided at the start event.
   bit m_wd_prev, m_busy, m_err, m_valid, m_done, m_error, m_zero;
   int m_left, m_err_k, m_err_index;
   int q_idx[$], q_rank[$], q_suit[$];
   int p_rank[9], p_suit[9];

   task automatic model_edge();
      bit start;
      bit used[64];
      int code;
      start = wd && !m_wd_prev;
      if (rst) begin
         m_wd_prev = 0; m_busy = 0; m_valid = 0; m_done = 0; m_error = 0;
         m_err_index = 0; m_zero = 1; m_left = 0;
         q_idx.delete(); q_rank.delete(); q_suit.delete();
         return;
      end
      m_wd_prev = wd;
      if (start && !m_busy) begin
         used = '{default: 0};
         m_err = 0; m_err_k = 0;
         for (int i = 0; i < 9; i++) begin
            code = int'(c[i]);
            if (!m_err && (code >= 52 || used[code])) begin
               m_err = 1; m_err_k = i;
            end
            used[code] = 1;
            p_rank[i] = code % 13 + 1;
            p_suit[i] = code / 13;
         end
         m_left = m_err ? m_err_k + 1 : 9;
         m_busy = 1; m_done = 0; m_error = 0; m_err_index = 0; m_valid = 0; m_zero = 0;
         q_idx.delete(); q_rank.delete(); q_suit.delete();
      end else if (m_busy) begin
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               if (m_err) begin
                  m_error = 1; m_err_index = m_err_k; m_busy = 0;
               end else begin
                  m_valid = 1;
                  for (int i = 0; i < 9; i++) begin
                     q_idx.push_back(i); q_rank.push_back(p_rank[i]); q_suit.push_back(p_suit[i]);
                  end
               end
            end
         end else if (ready) begin
            void'(q_idx.pop_front()); void'(q_rank.pop_front()); void'(q_suit.pop_front());
            if (q_idx.size() == 0) begin
               m_valid = 0; m_done = 1; m_busy = 0;
            end
         end
      end
   endtask

   task automatic compare();
      check_eq("out_valid", out_valid, m_valid);
      check_eq("hand_done", hand_done, m_done);
      check_eq("hand_error", hand_error, m_error);
      check_eq("err_index", err_index, m_err_index);
      if (m_valid) begin
         check_eq("out_index", out_index, q_idx[0]);
         check_eq("out_rank", out_rank, q_rank[0]);
         check_eq("out_suit", out_suit, q_suit[0]);
      end
      if (m_zero) begin
         check_eq("rst_index", out_index, 0);
         check_eq("rst_rank", out_rank, 0);
         check_eq("rst_suit", out_suit, 0);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare();
   endtask

   task automatic set_clean_hand();
      int deck[52];
      int j, t;
      for (int i = 0; i < 52; i++) deck[i] = i;
      for (int i = 51; i > 0; i--) begin
         j = $urandom_range(i);
         t = deck[i]; deck[i] = deck[j]; deck[j] = t;
      end
      for (int i = 0; i < 9; i++) c[i] = 6'(deck[i]);
   endtask

   task automatic wait_model_card(input int idx, input string tag);
      int n;
      n = 0;
      while (!(m_valid && q_idx[0] == idx) && n < 40) begin
         step();
         n++;
      end
      check_eq(tag, (m_valid && q_idx[0] == idx) ? 1 : 0, 1);
   endtask

   task automatic run_until_idle(input int budget, input bit rand_ready, input string tag);
      int n;
      n = 0;
      while (m_busy && n < budget) begin
         if (rand_ready) ready = 1'($urandom_range(1));
         step();
         n++;
      end
      check_eq(tag, m_busy, 0);
   endtask

   int r;

   initial begin
      rst = 1'b1; wd = 1'b0; ready = 1'b1;
      for (int i = 0; i < 9; i++) c[i] = '0;
      repeat (3) step();
      rst = 1'b0;
      step();

      // Directed clean hand covering every suit boundary.
      c = '{6'd0, 6'd12, 6'd13, 6'd25, 6'd26, 6'd38, 6'd39, 6'd51, 6'd5};
      wd = 1'b1;
      step();                    // E0
      repeat (8) step();         // E1..E8
      check_eq("valid_before_e9", out_valid, 0);
      step();                    // E9
      check_eq("valid_at_e9", out_valid, 1);
      check_eq("first_rank", out_rank, 1);
      repeat (8) step();         // E10..E17 accept cards 0..7
      check_eq("card8_rank", out_rank, 6);
      step();                    // E18 accepts card 8
      check_eq("done_after_last", hand_done, 1);
      check_eq("valid_after_last", out_valid, 0);
      wd = 1'b0;
      repeat (2) step();

      // Duplicate at position 3.
      c = '{6'd3, 6'd7, 6'd9, 6'd7, 6'd1, 6'd2, 6'd4, 6'd5, 6'd6};
      wd = 1'b1;
      repeat (4) step();         // E0..E3
      check_eq("dup_err_early", hand_error, 0);
      step();                    // E4
      check_eq("dup_err", hand_error, 1);
      check_eq("dup_idx", err_index, 3);
      repeat (4) step();
      wd = 1'b0;
      step();

      // Out-of-range code in position 5.
      c = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd55, 6'd6, 6'd7, 6'd8};
      wd = 1'b1;
      repeat (7) step();
      check_eq("range_idx", err_index, 5);
      wd = 1'b0;
      repeat (2) step();

      // Backpressure: stall on card 2, then toggle ready.
      set_clean_hand();
      ready = 1'b1; wd = 1'b1;
      wait_model_card(2, "wait_card2");
      ready = 1'b0;
      repeat (5) step();
      check_eq("stall_index", out_index, 2);
      while (m_busy && r < 60) begin
         ready = ~ready;
         step();
         r++;
      end
      check_eq("bp_done", hand_done, 1);
      wd = 1'b0;
      step();

      // Level flag held high for 100 cycles: exactly one hand.
      set_clean_hand();
      ready = 1'b1; wd = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (i == 30) set_clean_hand();
         step();
      end
      // Restart from DONE with fresh codes; a toggle during SEND is ignored.
      wd = 1'b0;
      step();
      set_clean_hand();
      wd = 1'b1;
      step();
      set_clean_hand();
      wait_model_card(3, "wait_send_toggle");
      wd = 1'b0; step();
      wd = 1'b1; step();
      run_until_idle(60, 1'b1, "toggle_run");

      // Reset while card 4 is presented, flag left high.
      wd = 1'b0; ready = 1'b1;
      step();
      set_clean_hand();
      wd = 1'b1;
      wait_model_card(4, "wait_card4");
      rst = 1'b1;
      step();
      check_eq("rst_valid", out_valid, 0);
      check_eq("rst_index4", out_index, 0);
      rst = 1'b0;
      step();                    // start event on first edge after reset
      run_until_idle(60, 1'b0, "post_rst_run");
      wd = 1'b0;
      step();

      // Randomized hands, ready, flag toggles and rare resets.
      for (int h = 0; h < 40; h++) begin
         case ($urandom_range(2))
            0: set_clean_hand();
            1: for (int i = 0; i < 9; i++) c[i] = 6'($urandom_range(63));
            default: begin
               set_clean_hand();
               c[$urandom_range(8)] = c[$urandom_range(8)];
            end
         endcase
         wd = 1'b1;
         for (int k = 0; k < 30; k++) begin
            ready = 1'($urandom_range(1));
            if ($urandom_range(7) == 0) wd = ~wd;
            rst = ($urandom_range(150) == 0);
            step();
         end
         rst = 1'b0;
         wd = 1'b0;
         ready = 1'b1;
         repeat (20) step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
